// File: rtl/proc_trace_pkg.sv
// Shared types for the processor trace capture block: FSM state and the
// 96-bit record stored per committed instruction.
package proc_trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } trace_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] data;
  } trace_rec_t;

endpackage

// File: rtl/proc_trace_capture_if.sv
// Trace input and drain port of the capture block, bundled so a producer/consumer
// can connect with one port.
interface proc_trace_capture_if;

  logic        trace_val;
  logic [31:0] trace_addr;
  logic [31:0] trace_inst;
  logic [31:0] trace_data;

  logic        deq_val;
  logic        deq_rdy;
  logic [31:0] deq_addr;
  logic [31:0] deq_inst;
  logic [31:0] deq_data;

  modport master (
    output trace_val, trace_addr, trace_inst, trace_data, deq_rdy,
    input  deq_val, deq_addr, deq_inst, deq_data
  );

  modport slave (
    input  trace_val, trace_addr, trace_inst, trace_data, deq_rdy,
    output deq_val, deq_addr, deq_inst, deq_data
  );

endinterface

// File: rtl/trace_fifo.sv
// Synchronous FIFO with val/rdy on both sides; full/empty derive from count.
// A write into a full FIFO is accepted only if the head leaves the same cycle.
module trace_fifo
  import proc_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter type         T     = trace_rec_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_val,
  output logic                     enq_rdy,
  input  T                         enq_rec,
  output logic                     deq_val,
  input  logic                     deq_rdy,
  output T                         deq_rec,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   CntFull = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CntOne  = (AW + 1)'(1);
  localparam logic [AW-1:0] PtrOne  = AW'(1);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          enq_fire, deq_fire;

  assign deq_val  = (count_q != '0);
  assign enq_rdy  = (count_q != CntFull) || deq_rdy;
  assign enq_fire = enq_val && enq_rdy;
  assign deq_fire = deq_val && deq_rdy;
  assign deq_rec  = mem_q[rd_ptr_q];
  assign count    = count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq_fire) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (deq_fire) rd_ptr_q <= rd_ptr_q + PtrOne;
      if (enq_fire && !deq_fire) count_q <= count_q + CntOne;
      else if (!enq_fire && deq_fire) count_q <= count_q - CntOne;
    end
  end

  // Storage is not reset; the read side is qualified by count.
  always_ff @(posedge clk) begin
    if (enq_fire) mem_q[wr_ptr_q] <= enq_rec;
  end

endmodule

// File: rtl/proc_trace_capture.sv
// Records the processor commit trace into a FIFO once armed and triggered, and
// keeps sticky overflow plus a saturating count of records lost to a full FIFO.
module proc_trace_capture
  import proc_trace_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DROP_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arm,
  input  logic                    disarm,
  input  logic                    trig_en,
  input  logic [31:0]             trig_addr,
  proc_trace_capture_if.slave     tr,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    capturing,
  output logic                    overflow,
  output logic [DROP_W-1:0]       drop_count
);

  localparam logic [DROP_W-1:0] DropOne = DROP_W'(1);

  trace_state_t      state_q, state_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_q, drop_d, drop_base;

  logic       trig_hit, rec_take, enq_rdy, drop, stats_clr;
  trace_rec_t enq_rec, head_rec;

  assign trig_hit  = tr.trace_val && (!trig_en || (tr.trace_addr == trig_addr));
  assign stats_clr = arm && !disarm;

  // Disarm suppresses the record of its own cycle; arm while ARMED restarts the
  // wait for the trigger rather than capturing.
  assign rec_take = !disarm && tr.trace_val &&
                    ((state_q == CAPTURE) || ((state_q == ARMED) && !arm && trig_hit));
  assign drop     = rec_take && !enq_rdy;

  assign enq_rec = '{addr: tr.trace_addr, inst: tr.trace_inst, data: tr.trace_data};

  always_comb begin
    state_d = state_q;
    if (disarm) begin
      state_d = IDLE;
    end else if (arm) begin
      state_d = ARMED;
    end else if ((state_q == ARMED) && trig_hit) begin
      state_d = CAPTURE;
    end
  end

  always_comb begin
    drop_base  = stats_clr ? '0 : drop_q;
    overflow_d = (stats_clr ? 1'b0 : overflow_q) | drop;
    drop_d     = drop_base;
    if (drop && (drop_base != '1)) drop_d = drop_base + DropOne;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .T     (trace_rec_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .enq_val (rec_take),
    .enq_rdy (enq_rdy),
    .enq_rec (enq_rec),
    .deq_val (tr.deq_val),
    .deq_rdy (tr.deq_rdy),
    .deq_rec (head_rec),
    .count   (count)
  );

  // Head fields read as zero when empty so reset clears them immediately.
  assign tr.deq_addr = tr.deq_val ? head_rec.addr : '0;
  assign tr.deq_inst = tr.deq_val ? head_rec.inst : '0;
  assign tr.deq_data = tr.deq_val ? head_rec.data : '0;

  assign capturing  = (state_q == CAPTURE);
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule
